pos_motion_broadcaster: RTL and testbench



---
 rtl/pos_motion_broadcaster.sv | 227 ++++++++++++++++++++++
 tb/tb_pos_motion_broadcaster.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_motion_broadcaster.sv
// Motion-update broadcaster: sweeps every position cell, adds each particle's
// signed displacement with periodic wrap, and broadcasts the new position plus
// its destination cell to all position caches.
//
// Handshake: there is no backpressure. out_data_valid is a one-cycle strobe
// that qualifies out_data/out_data_dst_cell, and the caches must accept every
// beat. Memory reads are fixed-latency: data for the address presented in
// cycle c is on in_rd_data/in_disp in cycle c+1.
module pos_motion_broadcaster #(
   parameter int DATA_WIDTH    = 32,
   parameter int CELL_ID_WIDTH = 4,
   parameter int ADDR_WIDTH    = 8,
   parameter int PARTICLE_NUM  = 220,
   parameter int CELL_NUM_X    = 3,
   parameter int CELL_NUM_Y    = 3,
   parameter int CELL_NUM_Z    = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic [3*CELL_ID_WIDTH-1:0]   out_rd_cell_sel,
   output logic [ADDR_WIDTH-1:0]        out_rd_address,
   output logic                         out_rden,
   input  logic [3*DATA_WIDTH-1:0]      in_rd_data,
   input  logic [3*DATA_WIDTH-1:0]      in_disp,
   output logic                         motion_update_enable,
   output logic [3*DATA_WIDTH-1:0]      out_data,
   output logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell,
   output logic                         out_data_valid,
   output logic                         busy,
   output logic                         done
);

   localparam int FRAC_WIDTH = DATA_WIDTH - CELL_ID_WIDTH;
   localparam int SW         = DATA_WIDTH + 1;
   localparam int RW         = DATA_WIDTH + CELL_ID_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_COUNT,
      S_LATCH_COUNT,
      S_RD_PART,
      S_WAIT_LAST,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [CELL_ID_WIDTH-1:0] cx_q, cy_q, cz_q;
   logic [ADDR_WIDTH-1:0]   count_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic                    part_vld_q;

   logic                    cell_init;
   logic                    cell_adv;
   logic                    cnt_load;
   logic                    idx_set;
   logic                    idx_inc;
   logic                    last_cell;
   logic [ADDR_WIDTH-1:0]   raw_count;
   logic [ADDR_WIDTH-1:0]   clamp_count;
   logic [RW-1:0]           wrap_x, wrap_y, wrap_z;

   // One component: add the displacement, wrap once into [0, BOX), and
   // return {destination coordinate (1-based), wrapped position}.
   function automatic logic [RW-1:0] wrap_comp(
      input logic [DATA_WIDTH-1:0] pos,
      input logic [DATA_WIDTH-1:0] disp,
      input int                    cell_num
   );
      logic signed [SW-1:0]    s;
      logic signed [SW-1:0]    box;
      logic [CELL_ID_WIDTH-1:0] coord;
      box = signed'(SW'(cell_num) << FRAC_WIDTH);
      s   = signed'({1'b0, pos}) + signed'({disp[DATA_WIDTH-1], disp});
      if (s[SW-1]) begin
         s = s + box;
      end else if (s >= box) begin
         s = s - box;
      end
      coord = s[DATA_WIDTH-1:FRAC_WIDTH] + CELL_ID_WIDTH'(1);
      return {coord, s[DATA_WIDTH-1:0]};
   endfunction

   assign raw_count   = in_rd_data[ADDR_WIDTH-1:0];
   assign clamp_count = (raw_count > ADDR_WIDTH'(PARTICLE_NUM)) ? ADDR_WIDTH'(PARTICLE_NUM) : raw_count;
   assign last_cell   = (cx_q == CELL_ID_WIDTH'(CELL_NUM_X)) &&
                        (cy_q == CELL_ID_WIDTH'(CELL_NUM_Y)) &&
                        (cz_q == CELL_ID_WIDTH'(CELL_NUM_Z));

   assign wrap_x = wrap_comp(in_rd_data[0*DATA_WIDTH +: DATA_WIDTH], in_disp[0*DATA_WIDTH +: DATA_WIDTH], CELL_NUM_X);
   assign wrap_y = wrap_comp(in_rd_data[1*DATA_WIDTH +: DATA_WIDTH], in_disp[1*DATA_WIDTH +: DATA_WIDTH], CELL_NUM_Y);
   assign wrap_z = wrap_comp(in_rd_data[2*DATA_WIDTH +: DATA_WIDTH], in_disp[2*DATA_WIDTH +: DATA_WIDTH], CELL_NUM_Z);

   // Read-side outputs decode directly from the state and cursor registers so
   // that address and enable line up with the cycle the state is entered.
   assign out_rd_cell_sel      = {cz_q, cy_q, cx_q};
   assign out_rden             = (state_q == S_RD_COUNT) || (state_q == S_RD_PART);
   assign out_rd_address       = (state_q == S_RD_PART) ? idx_q : '0;
   assign motion_update_enable = (state_q != S_IDLE) && (state_q != S_DONE);
   assign busy                 = (state_q != S_IDLE);
   assign done                 = (state_q == S_DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and cursor control strobes.
   always_comb begin
      state_d   = state_q;
      cell_init = 1'b0;
      cell_adv  = 1'b0;
      cnt_load  = 1'b0;
      idx_set   = 1'b0;
      idx_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cell_init = 1'b1;
               state_d   = S_RD_COUNT;
            end
         end
         S_RD_COUNT: begin
            state_d = S_LATCH_COUNT;
         end
         S_LATCH_COUNT: begin
            cnt_load = 1'b1;
            if (raw_count == '0) begin
               if (last_cell) begin
                  state_d = S_FLUSH;
               end else begin
                  cell_adv = 1'b1;
                  state_d  = S_RD_COUNT;
               end
            end else begin
               idx_set = 1'b1;
               state_d = S_RD_PART;
            end
         end
         S_RD_PART: begin
            if (idx_q == count_q) begin
               state_d = S_WAIT_LAST;
            end else begin
               idx_inc = 1'b1;
            end
         end
         S_WAIT_LAST: begin
            if (last_cell) begin
               state_d = S_FLUSH;
            end else begin
               cell_adv = 1'b1;
               state_d  = S_RD_COUNT;
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Cell cursor (x fastest, then y, then z), particle count and index.
   always_ff @(posedge clk) begin
      if (rst) begin
         cx_q    <= '0;
         cy_q    <= '0;
         cz_q    <= '0;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         if (cell_init) begin
            cx_q <= CELL_ID_WIDTH'(1);
            cy_q <= CELL_ID_WIDTH'(1);
            cz_q <= CELL_ID_WIDTH'(1);
         end else if (cell_adv) begin
            if (cx_q == CELL_ID_WIDTH'(CELL_NUM_X)) begin
               cx_q <= CELL_ID_WIDTH'(1);
               if (cy_q == CELL_ID_WIDTH'(CELL_NUM_Y)) begin
                  cy_q <= CELL_ID_WIDTH'(1);
                  cz_q <= cz_q + CELL_ID_WIDTH'(1);
               end else begin
                  cy_q <= cy_q + CELL_ID_WIDTH'(1);
               end
            end else begin
               cx_q <= cx_q + CELL_ID_WIDTH'(1);
            end
         end
         if (cnt_load) begin
            count_q <= clamp_count;
         end
         if (idx_set) begin
            idx_q <= ADDR_WIDTH'(1);
         end else if (idx_inc) begin
            idx_q <= idx_q + ADDR_WIDTH'(1);
         end
      end
   end

   // Broadcast pipeline: a particle address issued in RD_PART returns data
   // next cycle, which is wrapped and registered onto the bus the cycle after.
   always_ff @(posedge clk) begin
      if (rst) begin
         part_vld_q        <= 1'b0;
         out_data_valid    <= 1'b0;
         out_data          <= '0;
         out_data_dst_cell <= '0;
      end else begin
         part_vld_q     <= (state_q == S_RD_PART);
         out_data_valid <= part_vld_q;
         if (part_vld_q) begin
            out_data          <= {wrap_z[DATA_WIDTH-1:0], wrap_y[DATA_WIDTH-1:0], wrap_x[DATA_WIDTH-1:0]};
            out_data_dst_cell <= {wrap_z[RW-1:DATA_WIDTH], wrap_y[RW-1:DATA_WIDTH], wrap_x[RW-1:DATA_WIDTH]};
         end
      end
   end

endmodule

// File: tb/tb_pos_motion_broadcaster.sv
// Bench for pos_motion_broadcaster: a cell/displacement memory model, a
// table of single-particle vectors, and multi-cycle sequences for empty
// sweeps, address ordering, count clamping and mid-sweep reset.
module tb_pos_motion_broadcaster;

   localparam int DW  = 32;
   localparam int CW  = 4;
   localparam int AW  = 8;
   localparam int EW  = 3*CW + 3*DW;
   localparam int TRM = 512;

   logic            clk;
   logic            rst;
   logic            start;
   logic [3*CW-1:0] out_rd_cell_sel;
   logic [AW-1:0]   out_rd_address;
   logic            out_rden;
   logic [3*DW-1:0] in_rd_data;
   logic [3*DW-1:0] in_disp;
   logic            motion_update_enable;
   logic [3*DW-1:0] out_data;
   logic [3*CW-1:0] out_data_dst_cell;
   logic            out_data_valid;
   logic            busy;
   logic            done;

   pos_motion_broadcaster dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .out_rd_cell_sel      (out_rd_cell_sel),
      .out_rd_address       (out_rd_address),
      .out_rden             (out_rden),
      .in_rd_data           (in_rd_data),
      .in_disp              (in_disp),
      .motion_update_enable (motion_update_enable),
      .out_data             (out_data),
      .out_data_dst_cell    (out_data_dst_cell),
      .out_data_valid       (out_data_valid),
      .busy                 (busy),
      .done                 (done)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents, counts and scoreboard state.
   logic [7:0]      cnt_mem  [27];
   logic [3*DW-1:0] pos_mem  [27][256];
   logic [3*DW-1:0] disp_mem [27][256];
   logic [EW-1:0]   exp_q[$];
   int              checks;
   int              errors;
   int              beat_cnt;
   logic            tr_rden [TRM];
   logic [AW-1:0]   tr_addr [TRM];
   logic [3*CW-1:0] tr_sel  [TRM];

   typedef struct {
      logic [3*DW-1:0] pos;
      logic [3*DW-1:0] disp;
      logic [3*DW-1:0] exp_data;
      logic [3*CW-1:0] exp_dst;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int cidx(input logic [3*CW-1:0] s);
      int x, y, z;
      x = int'(s[3:0]);
      y = int'(s[7:4]);
      z = int'(s[11:8]);
      if (x < 1 || x > 3 || y < 1 || y > 3 || z < 1 || z > 3) return -1;
      return (x - 1) + 3*(y - 1) + 9*(z - 1);
   endfunction

   // Reference: 64-bit arithmetic, box = 3 << 28 per dimension.
   function automatic logic [EW-1:0] model(input logic [3*DW-1:0] p, input logic [3*DW-1:0] d);
      logic [EW-1:0] r;
      longint        s;
      longint        box;
      logic [31:0]   pc, dc;
      logic [31:0]   sl;
      r   = '0;
      box = 64'd3 << 28;
      for (int k = 0; k < 3; k++) begin
         pc = p[k*DW +: DW];
         dc = d[k*DW +: DW];
         s  = longint'({32'd0, pc}) + longint'({{32{dc[31]}}, dc});
         if (s < 0) s = s + box;
         else if (s >= box) s = s - box;
         sl = s[31:0];
         r[k*DW +: DW]       = sl;
         r[3*DW + k*CW +: CW] = sl[31:28] + 4'd1;
      end
      return r;
   endfunction

   // Memory model: registered read, one cycle of latency. Address 0 returns
   // the count in the low byte with junk above it.
   always @(posedge clk) begin : mem_model
      int ci;
      if (out_rden) begin
         ci = cidx(out_rd_cell_sel);
         if (ci < 0) begin
            in_rd_data <= '0;
            in_disp    <= '0;
         end else if (out_rd_address == '0) begin
            in_rd_data <= {{11{8'hA5}}, cnt_mem[ci]};
            in_disp    <= {3{32'h0700_0000}};
         end else begin
            in_rd_data <= pos_mem[ci][out_rd_address];
            in_disp    <= disp_mem[ci][out_rd_address];
         end
      end
   end

   // Scoreboard: every valid beat must match the head of the expected queue.
   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (!rst && out_data_valid) begin
         beat_cnt++;
         check("enable_with_valid", 128'(motion_update_enable), 128'(1));
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", {out_data_dst_cell, out_data});
         end else begin
            e = exp_q.pop_front();
            check("beat", 128'({out_data_dst_cell, out_data}), 128'(e));
         end
      end
   end

   task automatic clear_mem();
      for (int c = 0; c < 27; c++) begin
         cnt_mem[c] = 8'd0;
         for (int a = 0; a < 256; a++) begin
            pos_mem[c][a]  = '0;
            disp_mem[c][a] = '0;
         end
      end
   endtask

   task automatic fill_random(input int c, input int n);
      for (int a = 1; a <= n; a++) begin
         for (int k = 0; k < 3; k++) begin
            pos_mem[c][a][k*DW +: DW]  = 32'($urandom_range(32'h2FFF_FFFF, 0));
            disp_mem[c][a][k*DW +: DW] = 32'($urandom_range(32'h5FFF_FFFE, 0)) - 32'h2FFF_FFFF;
         end
      end
   endtask

   task automatic push_model();
      int n;
      for (int c = 0; c < 27; c++) begin
         n = (int'(cnt_mem[c]) > 220) ? 220 : int'(cnt_mem[c]);
         for (int a = 1; a <= n; a++) exp_q.push_back(model(pos_mem[c][a], disp_mem[c][a]));
      end
   endtask

   // Starts a sweep from a negedge and runs it to the done pulse, recording
   // the read side each cycle. Optionally re-pulses start mid-sweep.
   task automatic run_sweep(input bit extra_start, output int en_cyc, output int done_cnt);
      bit fin;
      fin      = 1'b0;
      en_cyc   = 0;
      done_cnt = 0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         if (motion_update_enable) en_cyc++;
         if (c < TRM) begin
            tr_rden[c] = out_rden;
            tr_addr[c] = out_rd_address;
            tr_sel[c]  = out_rd_cell_sel;
         end
         if (done) begin
            done_cnt++;
            fin = 1'b1;
            check("enable_low_in_done", 128'(motion_update_enable), 128'(0));
            check("busy_in_done", 128'(busy), 128'(1));
         end
         start = extra_start && (c == 3 || c == 9);
         if (!fin) @(negedge clk);
      end
      start = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL sweep_timeout actual=no_done required=done");
      end
      repeat (4) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (motion_update_enable) en_cyc++;
      end
      check("busy_after_sweep", 128'(busy), 128'(0));
   endtask

   task automatic sweep_and_check(input string tag, input bit extra, input int exp_en, input int exp_beats);
      int en, dn, b0;
      b0 = beat_cnt;
      run_sweep(extra, en, dn);
      check({tag, "_enable_cycles"}, 128'(en), 128'(exp_en));
      check({tag, "_done_pulses"}, 128'(dn), 128'(1));
      check({tag, "_beats"}, 128'(beat_cnt - b0), 128'(exp_beats));
      check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      int ci;
      bit hit;
      checks   = 0;
      errors   = 0;
      beat_cnt = 0;

      // Vector table: {pos, disp, expected data, expected dst}, all {z,y,x}.
      vecs[0] = '{{32'h0, 32'h0, 32'h1800_0000}, {32'h0, 32'h0, 32'h0900_0000},
                  {32'h0, 32'h0, 32'h2100_0000}, 12'h113};
      vecs[1] = '{{32'h0, 32'h0, 32'h0100_0000}, {32'h0, 32'h0, 32'hFE00_0000},
                  {32'h0, 32'h0, 32'h2F00_0000}, 12'h113};
      vecs[2] = '{{32'h0, 32'h0, 32'h2F00_0000}, {32'h0, 32'h0, 32'h0200_0000},
                  {32'h0, 32'h0, 32'h0100_0000}, 12'h111};
      vecs[3] = '{{32'h1000_0000, 32'h0, 32'h2FFF_FFFF}, {32'h0, 32'hFFFF_FFFF, 32'h1},
                  {32'h1000_0000, 32'h2FFF_FFFF, 32'h0}, 12'h231};
      vecs[4] = '{{32'h2000_0000, 32'h0FFF_FFFF, 32'h0}, {32'hE000_0000, 32'h1, 32'h2FFF_FFFF},
                  {32'h0, 32'h1000_0000, 32'h2FFF_FFFF}, 12'h123};
      vecs[5] = '{{32'h1800_0000, 32'h2FFF_FFFF, 32'h0}, {32'h1800_0000, 32'h2FFF_FFFF, 32'hD000_0001},
                  {32'h0, 32'h2FFF_FFFE, 32'h1}, 12'h131};

      // Reset.
      clear_mem();
      in_rd_data = '0;
      in_disp    = '0;
      rst        = 1'b1;
      start      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_enable", 128'(motion_update_enable), 128'(0));
      check("rst_valid", 128'(out_data_valid), 128'(0));
      check("rst_data", 128'(out_data), 128'(0));
      check("rst_dst", 128'(out_data_dst_cell), 128'(0));
      check("rst_rden", 128'(out_rden), 128'(0));
      check("rst_addr", 128'(out_rd_address), 128'(0));
      check("rst_sel", 128'(out_rd_cell_sel), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // Table: one particle per sweep in a varying source cell.
      // Enable: 4 cycles for the occupied cell, 26 empty cells, flush.
      for (int v = 0; v < 6; v++) begin
         clear_mem();
         ci = (v * 5) % 27;
         cnt_mem[ci]    = 8'd1;
         pos_mem[ci][1]  = vecs[v].pos;
         disp_mem[ci][1] = vecs[v].disp;
         exp_q.push_back({vecs[v].exp_dst, vecs[v].exp_data});
         sweep_and_check($sformatf("vec%0d", v), 1'b0, 4 + 26*2 + 1, 1);
      end

      // All cells empty: 27*2 cell cycles plus flush.
      clear_mem();
      sweep_and_check("empty", 1'b0, 27*2 + 1, 0);

      // Counts 3 and 0 then empty, with start re-pulsed while busy.
      clear_mem();
      cnt_mem[0] = 8'd3;
      fill_random(0, 3);
      fill_random(1, 4);
      push_model();
      sweep_and_check("cnt3", 1'b1, 6 + 2 + 25*2 + 1, 3);
      check("cnt3_rd_count_addr", 128'({tr_rden[0], tr_addr[0]}), 128'({1'b1, 8'd0}));
      check("cnt3_latch_rden", 128'(tr_rden[1]), 128'(0));
      check("cnt3_addr1", 128'({tr_rden[2], tr_addr[2]}), 128'({1'b1, 8'd1}));
      check("cnt3_addr2", 128'({tr_rden[3], tr_addr[3]}), 128'({1'b1, 8'd2}));
      check("cnt3_addr3", 128'({tr_rden[4], tr_addr[4]}), 128'({1'b1, 8'd3}));
      check("cnt3_wait_rden", 128'(tr_rden[5]), 128'(0));
      for (int c = 0; c < 6; c++) check($sformatf("cnt3_sel_hold%0d", c), 128'(tr_sel[c]), 128'(12'h111));
      check("cnt3_next_cell", 128'({tr_rden[6], tr_addr[6], tr_sel[6]}), 128'({1'b1, 8'd0, 12'h112}));

      // Clamp: stored count 250 reads only 220 particles; last cell has 2.
      clear_mem();
      cnt_mem[13] = 8'd250;
      fill_random(13, 250);
      cnt_mem[26] = 8'd2;
      fill_random(26, 2);
      push_model();
      sweep_and_check("clamp", 1'b0, 223 + 5 + 25*2 + 1, 222);

      // Reset while reading particles: abort with no beats and no done.
      clear_mem();
      cnt_mem[0] = 8'd5;
      fill_random(0, 5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         if (out_rden && out_rd_address == 8'd2) hit = 1'b1;
         else @(negedge clk);
      end
      check("abort_reached_rd_part", 128'(hit), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      check("abort_enable", 128'(motion_update_enable), 128'(0));
      check("abort_valid", 128'(out_data_valid), 128'(0));
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_done", 128'(done), 128'(0));
      check("abort_rden", 128'(out_rden), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // Restart after abort begins again at (1,1,1).
      clear_mem();
      cnt_mem[0]     = 8'd1;
      pos_mem[0][1]  = vecs[0].pos;
      disp_mem[0][1] = vecs[0].disp;
      exp_q.push_back({vecs[0].exp_dst, vecs[0].exp_data});
      sweep_and_check("restart", 1'b0, 4 + 26*2 + 1, 1);
      check("restart_first_read", 128'({tr_rden[0], tr_addr[0], tr_sel[0]}), 128'({1'b1, 8'd0, 12'h111}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
